progressbar_ovl: RTL and testbench
==================================

Name: progressbar_ovl

Overview:
Parametrised progress-bar overlay for the video path, the next generation of the fixed 128-pixel bar.
- Computes a fill level from `current`/`max` without a divider.
- Tracks raster position from blanking signals and emits a 1-bit overlay pixel plus a box-area enable for background dimming.
- Adds configurable geometry, reverse fill, and a frame-counted hold-off after `enable` drops.
- Sits beside the core's video mixer (tape/disk load indicator); the mixer ORs `pix` into the output colour.

Parameters:
- CNT_W, 25, width of `current`/`max`.
- BAR_W, 128, fill length in pixels; power of two, 8..512.
- BAR_H, 8, box height in lines; 5..32.
- X_OFFSET, 68, first box column, in active pixels from the end of hblank.
- Y_OFFSET, 20, first box line, in lines from the end of vblank.
- REVERSE, 0, 1 = fill grows right-to-left.
- HOLD_FRAMES, 0, frames the bar stays visible after `enable` falls; 0..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce_pix  in  1  pixel clock enable
- hblank  in  1  horizontal blank
- vblank  in  1  vertical blank
- enable  in  1  request to show the bar
- current  in  CNT_W  progress value
- max  in  CNT_W  full-scale value
- pix  out  1  overlay pixel, 1 = draw
- de  out  1  pixel lies inside the box area and the bar is visible
- fill  out  $clog2(BAR_W)+1  latched fill level, 0..BAR_W

Behaviour:
- Reset (async, reset_n=0):
  - pix=0, de=0, fill=0.
  - h/v counters=0.
  - Calc FSM in CALC with acc=0, iter=0.
  - Hold counter=0, visible=0.
- Fill calc (every clk, ignores ce_pix):
  - step = max >> log2(BAR_W); acc is CNT_W+1 bits, so it never wraps.
  - CALC: if step==0, set fill = (current>=max) ? BAR_W : 0, clear acc/iter, stay in CALC.
  - CALC, otherwise: if acc+step > current or iter==BAR_W, latch fill=iter, clear acc and iter, go to LATCH.
  - CALC, else: acc += step, iter += 1.
  - LATCH: one cycle, then CALC.
  - current > max clamps fill to BAR_W via the iter==BAR_W exit.
  - Worst-case update latency BAR_W+2 clk.
  - current/max changing mid-calc: the result may mix old and new inputs; it self-corrects on the next pass.
- Raster (only when ce_pix=1):
  - While hblank, h_cnt=0; otherwise h_cnt += 1.
  - v_cnt += 1 on the hblank rising edge (compared against the registered hblank).
  - vblank forces v_cnt=0, with priority over the increment.
  - Both counters 11 bits, wrapping silently.
- Visibility, updated on the vblank rising edge with ce_pix:
  - enable=1: visible=1, hold=HOLD_FRAMES.
  - enable=0 and hold>0: hold -= 1.
  - enable=0 and hold==0: visible=0.
  - visible = enable | (hold>0), evaluated combinationally from the registered hold.
  - A rising edge of enable shows the bar immediately; a falling edge hides it only after HOLD_FRAMES vblanks.
- Box geometry, with hc = h_cnt - X_OFFSET and vc = v_cnt - Y_OFFSET, both unsigned:
  - Box covers hc in 0..BAR_W+4 and vc in 0..BAR_H-1.
  - Border: vc 0 or BAR_H-1, or hc 0 or BAR_W+4.
  - Gap (0): vc 1 or BAR_H-2, or hc 1 or BAR_W+3.
  - Fill region: hc 2..BAR_W+1 with f = hc-2.
  - Fill pixel = 1 when f < fill (REVERSE=0), or when f >= BAR_W-fill (REVERSE=1).
- Outputs:
  - `pix` and `de` are registered on ce_pix, one pixel after the counters.
  - pix = visible & in_box & (border | fill pixel).
  - de = visible & in_box.
  - Both forced to 0 during hblank/vblank.

Decomposition:
- Shared package `ovl_pkg`:
  - calc FSM state enum (CALC, LATCH);
  - localparams for border and gap widths (1, 1);
  - function computing the fill-output width from BAR_W.
- One sub-module: `ovl_raster_cnt` (h/v counters with blank-edge detection), reusable by other overlays.
- The calc FSM and the pixel decode stay in the top.

Test Plan:
- Defaults, current=0, max=0x100000 → fill=0; line 22 shows pixels only at hc 0 and 132; row 20 is all 1s for hc 0..132.
- current=0x80000, max=0x100000 → fill=64 within 130 clk; on line 22, pix=1 for hc 2..65 and 0 at hc 66.
- REVERSE=1, same inputs → on line 22, pix=0 for hc 2..65 and 1 for hc 66..129.
- current=0x200000 > max=0x100000 → fill=128; max=50 (step 0) with current=10 → fill=0; current=50 → fill=128.
- HOLD_FRAMES=3: drop enable → bar still drawn for 3 frames, gone on the 4th; re-raise enable mid-hold → hold reloads and the bar stays visible.
- Assert reset_n mid-line with a bar displayed → pix=0, de=0, fill=0 asynchronously; after release, fill is correct within BAR_W+2 clk and the box is drawn correctly from the next full frame.

Source files
------------

// File: rtl/ovl_pkg.sv
// ovl_pkg: shared types, geometry constants and helpers for video overlays
package ovl_pkg;

    typedef enum logic {
        CALC,
        LATCH
    } calc_state_t;

    localparam int BORDER_W = 1;
    localparam int GAP_W    = 1;
    localparam int RASTER_W = 11;

    function automatic int fill_width(input int bar_w);
        return $clog2(bar_w) + 1;
    endfunction

endpackage

// File: rtl/ovl_raster_cnt.sv
// ovl_raster_cnt: horizontal/vertical raster counters derived from blanking signals
module ovl_raster_cnt
    import ovl_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce_pix,
    input  logic                hblank,
    input  logic                vblank,
    output logic [RASTER_W-1:0] h_cnt,
    output logic [RASTER_W-1:0] v_cnt,
    output logic                vblank_rise
);

    logic hblank_q;
    logic vblank_q;

    assign vblank_rise = vblank & ~vblank_q;

    // counters advance only on pixel-enable ticks; vblank clears the line count ahead of any increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else if (ce_pix) begin
            hblank_q <= hblank;
            vblank_q <= vblank;
            h_cnt    <= hblank ? '0 : h_cnt + 1'b1;
            v_cnt    <= vblank ? '0 : (hblank & ~hblank_q) ? v_cnt + 1'b1 : v_cnt;
        end
    end

endmodule

// File: rtl/progressbar_ovl.sv
// progressbar_ovl: parametrised progress-bar overlay with divider-free fill computation
module progressbar_ovl
    import ovl_pkg::*;
#(
    parameter int CNT_W       = 25,
    parameter int BAR_W       = 128,
    parameter int BAR_H       = 8,
    parameter int X_OFFSET    = 68,
    parameter int Y_OFFSET    = 20,
    parameter bit REVERSE     = 1'b0,
    parameter int HOLD_FRAMES = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ce_pix,
    input  logic                          hblank,
    input  logic                          vblank,
    input  logic                          enable,
    input  logic [CNT_W-1:0]              current,
    input  logic [CNT_W-1:0]              max,
    output logic                          pix,
    output logic                          de,
    output logic [fill_width(BAR_W)-1:0]  fill
);

    localparam int FW = fill_width(BAR_W);
    localparam int SH = $clog2(BAR_W);

    localparam logic [RASTER_W-1:0] B_W   = RASTER_W'(BORDER_W);
    localparam logic [RASTER_W-1:0] BOX_R = RASTER_W'(BAR_W + 4);
    localparam logic [RASTER_W-1:0] BOX_B = RASTER_W'(BAR_H - 1);
    localparam logic [RASTER_W-1:0] IN_L  = RASTER_W'(BORDER_W + GAP_W);
    localparam logic [RASTER_W-1:0] IN_R  = RASTER_W'(BORDER_W + GAP_W + BAR_W);
    localparam logic [RASTER_W-1:0] IN_B  = RASTER_W'(BAR_H - BORDER_W - GAP_W);

    calc_state_t       state, state_nx;
    logic [CNT_W:0]    acc, acc_nx, acc_sum;
    logic [FW-1:0]     iter, iter_nx, fill_nx;
    logic [CNT_W-1:0]  step;

    // one step is 1/BAR_W of full scale; counting steps that fit under current gives the fill
    assign step    = max >> SH;
    assign acc_sum = acc + {1'b0, step};

    // fill calc state, accumulator and latched result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CALC;
            acc   <= '0;
            iter  <= '0;
            fill  <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            iter  <= iter_nx;
            fill  <= fill_nx;
        end
    end

    // next-state: accumulate steps until they overshoot current or the bar is full
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        iter_nx  = iter;
        fill_nx  = fill;
        if (state == LATCH) begin
            state_nx = CALC;
        end else if (step == '0) begin
            fill_nx = (current >= max) ? FW'(BAR_W) : '0;
            acc_nx  = '0;
            iter_nx = '0;
        end else if (acc_sum > {1'b0, current} || iter == FW'(BAR_W)) begin
            fill_nx  = iter;
            acc_nx   = '0;
            iter_nx  = '0;
            state_nx = LATCH;
        end else begin
            acc_nx  = acc_sum;
            iter_nx = iter + 1'b1;
        end
    end

    logic [RASTER_W-1:0] h_cnt, v_cnt;
    logic                vblank_rise;

    ovl_raster_cnt u_raster (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .hblank      (hblank),
        .vblank      (vblank),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .vblank_rise (vblank_rise)
    );

    logic [7:0] hold;
    logic       visible;

    assign visible = enable | (hold != '0);

    // hold-off counter reloads while enabled and drains once per frame afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold <= '0;
        else if (ce_pix && vblank_rise)
            hold <= enable ? 8'(HOLD_FRAMES) : (hold != '0) ? hold - 1'b1 : hold;
    end

    logic [RASTER_W-1:0] hc, vc, f;
    logic                in_box, border, in_fill, fill_px, pix_d, de_d, blank;

    // unsigned wrap makes positions left of / above the box fall outside it
    assign hc      = h_cnt - RASTER_W'(X_OFFSET);
    assign vc      = v_cnt - RASTER_W'(Y_OFFSET);
    assign f       = hc - IN_L;
    assign in_box  = (hc <= BOX_R) && (vc <= BOX_B);
    assign border  = (vc < B_W) || (vc > BOX_B - B_W) || (hc < B_W) || (hc > BOX_R - B_W);
    assign in_fill = (hc >= IN_L) && (hc < IN_R) && (vc >= IN_L) && (vc < IN_B);
    assign fill_px = REVERSE ? (f >= RASTER_W'(BAR_W) - RASTER_W'(fill)) : (f < RASTER_W'(fill));
    assign blank   = hblank | vblank;
    assign pix_d   = visible & in_box & (border | (in_fill & fill_px));
    assign de_d    = visible & in_box;

    // overlay outputs lag the counters by one pixel and are dark during blanking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix <= 1'b0;
            de  <= 1'b0;
        end else if (ce_pix) begin
            pix <= pix_d & ~blank;
            de  <= de_d & ~blank;
        end
    end

endmodule

// File: tb/tb_progressbar_ovl.sv
// tb_progressbar_ovl: randomized self-checking bench against a frame-level behavioural model
module tb_progressbar_ovl;

    localparam int BW  = 128;
    localparam int BH  = 8;
    localparam int XO  = 68;
    localparam int YO  = 20;
    localparam int HF  = 3;
    localparam int ACT = 204;
    localparam int HBL = 3;
    localparam int NLN = 29;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_pix = 1'b0;
    logic        hblank = 1'b1;
    logic        vblank = 1'b1;
    logic        enable = 1'b0;
    logic [24:0] cur = '0;
    logic [24:0] mx = '0;
    logic        pix0, de0, pix1, de1, pix2, de2;
    logic [7:0]  fill0, fill1, fill2;

    int errors = 0;
    int checks = 0;
    int m_fill = 0;
    int hold2 = 0;
    bit last_vb = 1'b0;
    bit chk_en = 1'b1;
    bit e_ok = 1'b1;
    bit e_pix [3];
    bit e_de [3];

    progressbar_ovl dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .enable(enable), .current(cur), .max(mx), .pix(pix0), .de(de0), .fill(fill0)
    );

    progressbar_ovl #(.REVERSE(1'b1)) dut_rev (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .enable(enable), .current(cur), .max(mx), .pix(pix1), .de(de1), .fill(fill1)
    );

    progressbar_ovl #(.HOLD_FRAMES(HF)) dut_hold (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .enable(enable), .current(cur), .max(mx), .pix(pix2), .de(de2), .fill(fill2)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit in_box(input int x, input int y);
        return x >= XO && x <= XO + BW + 4 && y >= YO && y < YO + BH;
    endfunction

    function automatic bit drawn(input int x, input int y, input int f, input bit rev);
        int hc = x - XO;
        int vc = y - YO;
        if (!in_box(x, y)) return 1'b0;
        if (vc == 0 || vc == BH - 1 || hc == 0 || hc == BW + 4) return 1'b1;
        if (vc == 1 || vc == BH - 2 || hc < 2 || hc > BW + 1) return 1'b0;
        return rev ? (hc - 2 >= BW - f) : (hc - 2 < f);
    endfunction

    task automatic pixel(input bit hb, input bit vb, input int x, input int y);
        logic [2:0] ap, ad;
        bit vis, ep, ed;
        int hold_now;
        if (e_ok && $urandom_range(0, 15) == 0) begin
            ce_pix = 1'b0;
            @(posedge clk);
            #1;
            ap = {pix2, pix1, pix0};
            ad = {de2, de1, de0};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ap[i] !== e_pix[i] || ad[i] !== e_de[i]) begin
                    errors++;
                    $display("FAIL ce_idle dut%0d x=%0d y=%0d pix/de got=%b%b exp=%b%b", i, x, y, ap[i], ad[i], e_pix[i], e_de[i]);
                end
            end
        end
        ce_pix = 1'b1;
        hblank = hb;
        vblank = vb;
        hold_now = hold2;
        if (vb && !last_vb) hold2 = enable ? HF : (hold2 > 0 ? hold2 - 1 : 0);
        last_vb = vb;
        @(posedge clk);
        #1;
        ap = {pix2, pix1, pix0};
        ad = {de2, de1, de0};
        e_ok = chk_en || hb || vb;
        for (int i = 0; i < 3; i++) begin
            vis = enable || (i == 2 && hold_now > 0);
            ed = !(hb || vb) && vis && in_box(x, y);
            ep = !(hb || vb) && vis && drawn(x, y, m_fill, i == 1);
            e_pix[i] = ep;
            e_de[i] = ed;
            if (e_ok) begin
                checks++;
                if (ap[i] !== ep || ad[i] !== ed) begin
                    errors++;
                    $display("FAIL raster dut%0d x=%0d y=%0d pix/de got=%b%b exp=%b%b", i, x, y, ap[i], ad[i], ep, ed);
                end
            end
        end
    endtask

    task automatic draw_line(input int y, input int len, input bit vb);
        for (int x = 0; x < len; x++) pixel(1'b0, vb, x, y);
        for (int k = 0; k < HBL; k++) pixel(1'b1, vb, 0, y);
    endtask

    task automatic draw_frame(input int en_line, input bit en_val);
        draw_line(0, 4, 1'b1);
        for (int y = 0; y < NLN; y++) begin
            if (y == en_line) enable = en_val;
            draw_line(y, (y >= YO && y < YO + BH) ? ACT : int'($urandom_range(1, 6)), 1'b0);
        end
    endtask

    task automatic apply(input int c, input int m);
        int st;
        cur = 25'(c);
        mx = 25'(m);
        st = m / BW;
        m_fill = (st == 0) ? (c >= m ? BW : 0) : ((c / st > BW) ? BW : c / st);
        ce_pix = 1'b0;
        repeat (2 * (BW + 2) + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ce_pix = 1'b0;
        cur = '0;
        mx = 25'h100000;
        m_fill = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pix0, pix1, pix2, de0, de1, de2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs pix=%b%b%b de=%b%b%b exp=0", pix0, pix1, pix2, de0, de1, de2);
        end
        checks++;
        if ({fill0, fill1, fill2} !== 24'h0) begin
            errors++;
            $display("FAIL reset_fill got=%0d/%0d/%0d exp=0", fill0, fill1, fill2);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({fill0, fill1, fill2} !== 24'h0) begin
            errors++;
            $display("FAIL empty_fill_after_reset got=%0d/%0d/%0d exp=0", fill0, fill1, fill2);
        end
    endtask

    task automatic test_empty();
        apply(0, 25'h100000);
        checks++;
        if ({fill0, fill1, fill2} !== {3{8'(m_fill)}}) begin
            errors++;
            $display("FAIL empty_fill got=%0d/%0d/%0d exp=%0d", fill0, fill1, fill2, m_fill);
        end
        enable = 1'b1;
        draw_frame(-1, 1'b0);
    endtask

    task automatic test_half();
        apply(25'h80000, 25'h100000);
        checks++;
        if ({fill0, fill1, fill2} !== {3{8'(m_fill)}} || m_fill != 64) begin
            errors++;
            $display("FAIL half_fill got=%0d/%0d/%0d exp=%0d", fill0, fill1, fill2, m_fill);
        end
        draw_frame(-1, 1'b0);
    endtask

    task automatic test_clamp();
        int cs [3] = '{25'h200000, 10, 50};
        int ms [3] = '{25'h100000, 50, 50};
        int ex [3] = '{128, 0, 128};
        for (int n = 0; n < 3; n++) begin
            apply(cs[n], ms[n]);
            checks++;
            if ({fill0, fill1, fill2} !== {3{8'(ex[n])}}) begin
                errors++;
                $display("FAIL clamp_fill cur=%0d max=%0d got=%0d/%0d/%0d exp=%0d", cs[n], ms[n], fill0, fill1, fill2, ex[n]);
            end
        end
        apply(25'h200000, 25'h100000);
        draw_frame(-1, 1'b0);
    endtask

    task automatic test_random_fill();
        int c, m;
        for (int n = 0; n < 12; n++) begin
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(128, 25'h1ffffff));
            c = int'($urandom_range(0, (m > 25'hffffff) ? 25'h1ffffff : 2 * m + 1));
            ce_pix = 1'b0;
            cur = 25'($urandom);
            mx = 25'($urandom);
            repeat ($urandom_range(1, 120)) @(posedge clk);
            apply(c, m);
            checks++;
            if ({fill0, fill1, fill2} !== {3{8'(m_fill)}}) begin
                errors++;
                $display("FAIL random_fill cur=%0d max=%0d got=%0d/%0d/%0d exp=%0d", c, m, fill0, fill1, fill2, m_fill);
            end
            repeat (BW + 10) @(posedge clk);
            #1;
            checks++;
            if ({fill0, fill1, fill2} !== {3{8'(m_fill)}}) begin
                errors++;
                $display("FAIL random_fill_stable cur=%0d max=%0d got=%0d/%0d/%0d exp=%0d", c, m, fill0, fill1, fill2, m_fill);
            end
        end
        draw_frame(-1, 1'b0);
    endtask

    task automatic test_hold();
        apply(25'h60000, 25'h100000);
        enable = 1'b1;
        draw_frame(0, 1'b0);
        for (int k = 0; k < 3; k++) draw_frame(-1, 1'b0);
        checks++;
        if (hold2 != 0) begin
            errors++;
            $display("FAIL hold_model_drained got=%0d exp=0", hold2);
        end
        draw_frame(0, 1'b1);
        draw_frame(0, 1'b0);
        draw_frame(10, 1'b1);
        draw_frame(0, 1'b0);
        for (int k = 0; k < 3; k++) draw_frame(-1, 1'b0);
        enable = 1'b1;
    endtask

    task automatic test_reset_midline();
        apply(25'h80000, 25'h100000);
        enable = 1'b1;
        draw_frame(-1, 1'b0);
        draw_line(0, 4, 1'b1);
        for (int y = 0; y < 22; y++) draw_line(y, (y >= YO) ? ACT : int'($urandom_range(1, 6)), 1'b0);
        for (int x = 0; x < 100; x++) pixel(1'b0, 1'b0, x, 22);
        ce_pix = 1'b0;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({pix0, pix1, pix2, de0, de1, de2} !== 6'b0 || {fill0, fill1, fill2} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset pix=%b%b%b de=%b%b%b fill=%0d/%0d/%0d exp=0", pix0, pix1, pix2, de0, de1, de2, fill0, fill1, fill2);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold2 = 0;
        last_vb = 1'b0;
        e_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e_pix[i] = 1'b0;
            e_de[i] = 1'b0;
        end
        repeat (BW + 2) @(posedge clk);
        #1;
        checks++;
        if ({fill0, fill1, fill2} !== {3{8'(m_fill)}}) begin
            errors++;
            $display("FAIL fill_after_reset got=%0d/%0d/%0d exp=%0d", fill0, fill1, fill2, m_fill);
        end
        chk_en = 1'b0;
        for (int x = 100; x < ACT; x++) pixel(1'b0, 1'b0, x, 22);
        for (int k = 0; k < HBL; k++) pixel(1'b1, 1'b0, 0, 22);
        for (int y = 23; y < NLN; y++) draw_line(y, (y < YO + BH) ? ACT : 4, 1'b0);
        chk_en = 1'b1;
        draw_frame(-1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_half();
        test_clamp();
        test_random_fill();
        test_hold();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
